// File: rtl/conv1d_engine_pkg.sv
// rtl/conv1d_engine_pkg.sv - shared types and helpers for the 1-D convolution engine
// Purpose: FSM state encoding, accumulator width and result saturation helpers.
// Ports: none (package).
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FILT,
    LOAD_WIN,
    MAC,
    WRITE,
    SHIFT,
    DONE
  } state_t;

  // Sum of TAPS products of two data_w-bit values can never overflow this width.
  function automatic int acc_width(input int data_w, input int taps);
    return 2 * data_w + $clog2(taps);
  endfunction

  // Clamp to the all-ones data_w value, or keep only the low data_w bits.
  function automatic logic [63:0] saturate(input logic [63:0] acc, input int data_w,
                                           input bit sat);
    logic [63:0] max_v;
    max_v = (64'd1 << data_w) - 64'd1;
    if (!sat) begin
      return acc & max_v;
    end
    return (acc > max_v) ? max_v : acc;
  endfunction

endpackage

// File: rtl/conv1d_engine_if.sv
// rtl/conv1d_engine_if.sv - single-port memory bus between engine and memory
// Purpose: groups the read/write memory strobes, address and data.
// Ports: mem_rd_en, mem_addr, mem_wr_en, mem_wr_data (master drives); mem_rd_data
//        (slave drives, valid the cycle after mem_rd_en).
interface conv1d_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;

  modport master (
    output mem_rd_en, mem_addr, mem_wr_en, mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_addr, mem_wr_en, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/conv1d_engine_mac.sv
// rtl/conv1d_engine_mac.sv - multiply-accumulate unit with saturating output stage
// Purpose: acc = clr ? a*b : acc + a*b when en; result is acc saturated or truncated.
// Ports: clk, rst (async high), clr, en, a, b (DATA_W), result (DATA_W).
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAPS   = 4,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);
  localparam int ACC_W = acc_width(DATA_W, TAPS);

  logic [ACC_W-1:0] acc_q, acc_d, prod;

  always_comb begin
    prod  = ACC_W'(a) * ACC_W'(b);
    acc_d = acc_q;
    // clr with en loads the first product so the MAC loop needs no separate clear cycle.
    if (clr) begin
      acc_d = en ? prod : '0;
    end else if (en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign result = DATA_W'(saturate(64'(acc_q), DATA_W, SAT != 0));
endmodule

// File: rtl/conv1d_engine.sv
// rtl/conv1d_engine.sv - 1-D convolution engine top: FSM, window storage, addressing
// Purpose: loads TAPS coefficients and a sliding window from memory, computes each
//          output with conv_mac and writes it back; one new sample read per output.
// Ports: clk, rst (async high), start, filt_base/in_base/out_base/in_len (ADDR_W),
//        mem (memory bus master), busy/done/err (registered status).
module conv1d_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int TAPS   = 4,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] filt_base,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [ADDR_W-1:0] in_len,
  conv1d_engine_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CNT_W = $clog2(TAPS + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] filt_base_q, filt_base_d, in_base_q, in_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d, len_q, len_d;
  logic [DATA_W-1:0] coeff_q [TAPS];
  logic [DATA_W-1:0] coeff_d [TAPS];
  logic [DATA_W-1:0] win_q [TAPS];
  logic [DATA_W-1:0] win_d [TAPS];
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic              too_short;
  logic [ADDR_W-1:0] m_total;
  logic              mac_clr, mac_en;
  logic [DATA_W-1:0] mac_a, mac_b, mac_result;

  assign too_short = in_len < ADDR_W'(TAPS);
  assign m_total   = len_q - ADDR_W'(TAPS - 1);

  conv_mac #(.DATA_W(DATA_W), .TAPS(TAPS), .SAT(SAT)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .a      (mac_a),
    .b      (mac_b),
    .result (mac_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      j_q         <= '0;
      filt_base_q <= '0;
      in_base_q   <= '0;
      out_base_q  <= '0;
      len_q       <= '0;
      coeff_q     <= '{default: '0};
      win_q       <= '{default: '0};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      j_q         <= j_d;
      filt_base_q <= filt_base_d;
      in_base_q   <= in_base_d;
      out_base_q  <= out_base_d;
      len_q       <= len_d;
      coeff_q     <= coeff_d;
      win_q       <= win_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = too_short ? DONE : LOAD_FILT;
      LOAD_FILT: if (cnt_q == CNT_W'(TAPS)) state_d = LOAD_WIN;
      LOAD_WIN:  if (cnt_q == CNT_W'(TAPS)) state_d = MAC;
      MAC:       if (cnt_q == CNT_W'(TAPS - 1)) state_d = WRITE;
      WRITE:     state_d = (j_q + ADDR_W'(1) == m_total) ? DONE : SHIFT;
      SHIFT:     if (cnt_q == CNT_W'(1)) state_d = MAC;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d           = cnt_q;
    j_d             = j_q;
    filt_base_d     = filt_base_q;
    in_base_d       = in_base_q;
    out_base_d      = out_base_q;
    len_d           = len_q;
    coeff_d         = coeff_q;
    win_d           = win_q;
    mem.mem_rd_en   = 1'b0;
    mem.mem_wr_en   = 1'b0;
    mem.mem_addr    = '0;
    mem.mem_wr_data = '0;
    mac_clr         = 1'b0;
    mac_en          = 1'b0;
    mac_a           = '0;
    mac_b           = '0;
    busy_d          = state_d != IDLE;
    done_d          = state_d == DONE;
    err_d           = (state_q == IDLE) && start && too_short;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        j_d   = '0;
        if (start) begin
          filt_base_d = filt_base;
          in_base_d   = in_base;
          out_base_d  = out_base;
          len_d       = in_len;
        end
      end
      LOAD_FILT, LOAD_WIN: begin
        // Cycle c issues read c and captures the data of read c-1.
        if (cnt_q < CNT_W'(TAPS)) begin
          mem.mem_rd_en = 1'b1;
          mem.mem_addr  = ((state_q == LOAD_FILT) ? filt_base_q : in_base_q) + ADDR_W'(cnt_q);
        end
        for (int i = 0; i < TAPS; i++) begin
          if (cnt_q == CNT_W'(i + 1)) begin
            if (state_q == LOAD_FILT) coeff_d[i] = mem.mem_rd_data;
            else                      win_d[i]   = mem.mem_rd_data;
          end
        end
        cnt_d = (cnt_q == CNT_W'(TAPS)) ? '0 : cnt_q + CNT_W'(1);
      end
      MAC: begin
        mac_en  = 1'b1;
        mac_clr = cnt_q == '0;
        for (int i = 0; i < TAPS; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            mac_a = win_q[i];
            mac_b = coeff_q[i];
          end
        end
        cnt_d = (cnt_q == CNT_W'(TAPS - 1)) ? '0 : cnt_q + CNT_W'(1);
      end
      WRITE: begin
        mem.mem_wr_en   = 1'b1;
        mem.mem_addr    = out_base_q + j_q;
        mem.mem_wr_data = mac_result;
        j_d             = j_q + ADDR_W'(1);
        cnt_d           = '0;
      end
      SHIFT: begin
        // j already counts the written outputs, so this fetches the newest sample.
        if (cnt_q == '0) begin
          mem.mem_rd_en = 1'b1;
          mem.mem_addr  = in_base_q + j_q + ADDR_W'(TAPS - 1);
          cnt_d         = CNT_W'(1);
        end else begin
          for (int i = 0; i < TAPS - 1; i++) win_d[i] = win_q[i + 1];
          win_d[TAPS-1] = mem.mem_rd_data;
          cnt_d         = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
endmodule

// File: tb/tb_conv1d_engine.sv
// tb/tb_conv1d_engine.sv - directed self-checking bench for conv1d_engine
module tb_conv1d_engine;
  import conv_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start_ns = 1'b0;
  logic [7:0] filt_base = '0, in_base = '0, out_base = '0, in_len = '0;
  logic       busy, done, err, busy_ns, done_ns, err_ns;

  conv1d_engine_if #(.DATA_W(8), .ADDR_W(8)) mif ();
  conv1d_engine_if #(.DATA_W(8), .ADDR_W(8)) mif_ns ();

  conv1d_engine #(.DATA_W(8), .ADDR_W(8), .TAPS(4), .SAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .filt_base(filt_base), .in_base(in_base),
    .out_base(out_base), .in_len(in_len), .mem(mif), .busy(busy), .done(done), .err(err)
  );

  conv1d_engine #(.DATA_W(8), .ADDR_W(8), .TAPS(4), .SAT(0)) dut_ns (
    .clk(clk), .rst(rst), .start(start_ns), .filt_base(filt_base), .in_base(in_base),
    .out_base(out_base), .in_len(in_len), .mem(mif_ns), .busy(busy_ns), .done(done_ns),
    .err(err_ns)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] mem_ns [256];

  always @(posedge clk) begin
    if (mif.mem_rd_en) mif.mem_rd_data <= mem[mif.mem_addr];
    if (mif_ns.mem_rd_en) mif_ns.mem_rd_data <= mem_ns[mif_ns.mem_addr];
  end

  int         busy_cnt = 0, done_cnt = 0, err_cnt = 0, done_ns_cnt = 0;
  int         overlap_cnt = 0, idle_addr_cnt = 0, lone_err_cnt = 0;
  logic [7:0] wr_addr_log[$], wr_data_log[$], rd_addr_log[$];
  logic [7:0] wr_addr_ns_log[$], wr_data_ns_log[$];

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (err && !done) lone_err_cnt++;
    if (done_ns) done_ns_cnt++;
    if (mif.mem_wr_en) begin
      wr_addr_log.push_back(mif.mem_addr);
      wr_data_log.push_back(mif.mem_wr_data);
    end
    if (mif.mem_rd_en) rd_addr_log.push_back(mif.mem_addr);
    if (mif.mem_rd_en && mif.mem_wr_en) overlap_cnt++;
    if (!mif.mem_rd_en && !mif.mem_wr_en && mif.mem_addr != 8'd0) idle_addr_cnt++;
    if (mif_ns.mem_wr_en) begin
      wr_addr_ns_log.push_back(mif_ns.mem_addr);
      wr_data_ns_log.push_back(mif_ns.mem_wr_data);
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_basic [5] = '{8'd30, 8'd40, 8'd50, 8'd60, 8'd70};

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic init_basic_mem();
    for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) mem[16 + i] = 8'(i + 1);
  endtask

  task automatic start_job(input logic [7:0] fb, input logic [7:0] ib, input logic [7:0] ob,
                           input logic [7:0] n);
    tick();
    filt_base = fb; in_base = ib; out_base = ob; in_len = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 2000) begin
      tick();
      t++;
    end
    ok = done_cnt != d0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({busy, done, err} !== 3'b000) $display("FAIL reset_status got %b want 000", {busy, done, err});
    else pass_cnt++;
    total_cnt++;
    if ({mif.mem_rd_en, mif.mem_wr_en} !== 2'b00)
      $display("FAIL reset_strobes got %b want 00", {mif.mem_rd_en, mif.mem_wr_en});
    else pass_cnt++;
    total_cnt++;
    if (mif.mem_addr !== 8'd0) $display("FAIL reset_addr got %0d want 0", mif.mem_addr);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (rd_addr_log.size() + wr_addr_log.size() !== 0)
      $display("FAIL reset_no_access got %0d accesses want 0", rd_addr_log.size() + wr_addr_log.size());
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int w0, b0, d0, e0;
    bit ok;
    init_basic_mem();
    w0 = wr_addr_log.size(); b0 = busy_cnt; d0 = done_cnt; e0 = err_cnt;
    start_job(8'd0, 8'd16, 8'd32, 8'd8);
    wait_done(d0, ok);
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL basic_timeout got no done want done");
    else pass_cnt++;
    total_cnt++;
    if (wr_addr_log.size() - w0 !== 5) $display("FAIL basic_wr_count got %0d want 5", wr_addr_log.size() - w0);
    else pass_cnt++;
    for (int i = 0; i < 5 && w0 + i < wr_addr_log.size(); i++) begin
      total_cnt++;
      if (wr_addr_log[w0+i] !== 8'(32 + i) || wr_data_log[w0+i] !== exp_basic[i])
        $display("FAIL basic_write%0d got mem[%0d]=%0d want mem[%0d]=%0d", i, wr_addr_log[w0+i],
                 wr_data_log[w0+i], 32 + i, exp_basic[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy_cnt - b0 !== 44) $display("FAIL basic_busy got %0d cycles want 44", busy_cnt - b0);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL basic_done_err got done=%0d err=%0d want done=1 err=0", done_cnt - d0, err_cnt - e0);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int w0, wn0, d0, dn0, t;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      mem[64 + i] = 8'd255; mem[80 + i] = 8'd255;
      mem_ns[64 + i] = 8'd255; mem_ns[80 + i] = 8'd255;
    end
    w0 = wr_addr_log.size(); d0 = done_cnt;
    start_job(8'd64, 8'd80, 8'd96, 8'd4);
    wait_done(d0, ok);
    total_cnt++;
    if (ok !== 1'b1 || wr_addr_log.size() - w0 !== 1)
      $display("FAIL sat1_writes got %0d writes want 1", wr_addr_log.size() - w0);
    else pass_cnt++;
    if (wr_addr_log.size() > w0) begin
      total_cnt++;
      if (wr_addr_log[w0] !== 8'd96 || wr_data_log[w0] !== 8'd255)
        $display("FAIL sat1_value got mem[%0d]=%0d want mem[96]=255", wr_addr_log[w0], wr_data_log[w0]);
      else pass_cnt++;
    end
    wn0 = wr_addr_ns_log.size(); dn0 = done_ns_cnt;
    tick();
    start_ns = 1'b1;
    tick();
    start_ns = 1'b0;
    t = 0;
    while (done_ns_cnt == dn0 && t < 2000) begin
      tick();
      t++;
    end
    tick();
    total_cnt++;
    if (done_ns_cnt == dn0 || wr_addr_ns_log.size() - wn0 !== 1)
      $display("FAIL sat0_writes got %0d writes want 1", wr_addr_ns_log.size() - wn0);
    else pass_cnt++;
    if (wr_addr_ns_log.size() > wn0) begin
      total_cnt++;
      if (wr_addr_ns_log[wn0] !== 8'd96 || wr_data_ns_log[wn0] !== 8'd4)
        $display("FAIL sat0_value got mem[%0d]=%0d want mem[96]=4", wr_addr_ns_log[wn0], wr_data_ns_log[wn0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_short_job();
    int a0, b0;
    a0 = rd_addr_log.size() + wr_addr_log.size(); b0 = busy_cnt;
    start_job(8'd0, 8'd16, 8'd48, 8'd3);
    total_cnt++;
    if ({busy, done, err} !== 3'b111) $display("FAIL short_pulse got %b want 111", {busy, done, err});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, done, err} !== 3'b000) $display("FAIL short_after got %b want 000", {busy, done, err});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rd_addr_log.size() + wr_addr_log.size() - a0 !== 0 || busy_cnt - b0 !== 1)
      $display("FAIL short_access got access=%0d busy=%0d want access=0 busy=1",
               rd_addr_log.size() + wr_addr_log.size() - a0, busy_cnt - b0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_job();
    int w0, r0, d0, t;
    bit ok;
    init_basic_mem();
    w0 = wr_addr_log.size();
    start_job(8'd0, 8'd16, 8'd32, 8'd8);
    t = 0;
    while (wr_addr_log.size() == w0 && t < 200) begin
      tick();
      t++;
    end
    tick(); tick(); tick(); tick();
    total_cnt++;
    if (dut.state_q !== MAC) $display("FAIL mid_state_pre got %s want MAC", dut.state_q.name());
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, err, mif.mem_rd_en, mif.mem_wr_en} !== 5'b0 || mif.mem_addr !== 8'd0 ||
        mif.mem_wr_data !== 8'd0)
      $display("FAIL mid_reset_outputs got %b addr=%0d data=%0d want 0",
               {busy, done, err, mif.mem_rd_en, mif.mem_wr_en}, mif.mem_addr, mif.mem_wr_data);
    else pass_cnt++;
    total_cnt++;
    if (dut.state_q !== IDLE) $display("FAIL mid_reset_state got %s want IDLE", dut.state_q.name());
    else pass_cnt++;
    w0 = wr_addr_log.size(); r0 = rd_addr_log.size();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total_cnt++;
    if (wr_addr_log.size() - w0 !== 0 || rd_addr_log.size() - r0 !== 0 || busy !== 1'b0)
      $display("FAIL mid_reset_quiet got wr=%0d rd=%0d busy=%b want 0 0 0",
               wr_addr_log.size() - w0, rd_addr_log.size() - r0, busy);
    else pass_cnt++;
    w0 = wr_addr_log.size(); d0 = done_cnt;
    start_job(8'd0, 8'd16, 8'd32, 8'd8);
    wait_done(d0, ok);
    total_cnt++;
    if (ok !== 1'b1 || wr_addr_log.size() - w0 !== 5)
      $display("FAIL rerun_wr_count got %0d want 5", wr_addr_log.size() - w0);
    else pass_cnt++;
    for (int i = 0; i < 5 && w0 + i < wr_addr_log.size(); i++) begin
      total_cnt++;
      if (wr_addr_log[w0+i] !== 8'(32 + i) || wr_data_log[w0+i] !== exp_basic[i])
        $display("FAIL rerun_write%0d got mem[%0d]=%0d want mem[%0d]=%0d", i, wr_addr_log[w0+i],
                 wr_data_log[w0+i], 32 + i, exp_basic[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_while_busy();
    int w0, d0, e0;
    bit ok;
    init_basic_mem();
    w0 = wr_addr_log.size(); d0 = done_cnt; e0 = err_cnt;
    start_job(8'd0, 8'd16, 8'd32, 8'd8);
    for (int i = 0; i < 6; i++) tick();
    total_cnt++;
    if (dut.state_q !== LOAD_WIN) $display("FAIL busy_start_state got %s want LOAD_WIN", dut.state_q.name());
    else pass_cnt++;
    filt_base = 8'd50; in_base = 8'd100; out_base = 8'd200; in_len = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, ok);
    total_cnt++;
    if (ok !== 1'b1 || wr_addr_log.size() - w0 !== 5 || err_cnt - e0 !== 0 || done_cnt - d0 !== 1)
      $display("FAIL busy_start_job got writes=%0d err=%0d done=%0d want 5 0 1",
               wr_addr_log.size() - w0, err_cnt - e0, done_cnt - d0);
    else pass_cnt++;
    for (int i = 0; i < 5 && w0 + i < wr_addr_log.size(); i++) begin
      total_cnt++;
      if (wr_addr_log[w0+i] !== 8'(32 + i) || wr_data_log[w0+i] !== exp_basic[i])
        $display("FAIL busy_start_write%0d got mem[%0d]=%0d want mem[%0d]=%0d", i, wr_addr_log[w0+i],
                 wr_data_log[w0+i], 32 + i, exp_basic[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_addr_wrap();
    int w0, r0, d0;
    bit ok;
    logic [7:0] exp_rd [9] = '{8'd8, 8'd9, 8'd10, 8'd11, 8'd254, 8'd255, 8'd0, 8'd1, 8'd2};
    logic [7:0] exp_wr [2] = '{8'd89, 8'd76};
    for (int i = 0; i < 4; i++) mem[8 + i] = 8'(i + 1);
    mem[254] = 8'd10; mem[255] = 8'd20; mem[0] = 8'd5; mem[1] = 8'd6; mem[2] = 8'd7;
    w0 = wr_addr_log.size(); r0 = rd_addr_log.size(); d0 = done_cnt;
    start_job(8'd8, 8'd254, 8'd40, 8'd5);
    wait_done(d0, ok);
    total_cnt++;
    if (ok !== 1'b1 || rd_addr_log.size() - r0 !== 9)
      $display("FAIL wrap_rd_count got %0d want 9", rd_addr_log.size() - r0);
    else pass_cnt++;
    for (int i = 0; i < 9 && r0 + i < rd_addr_log.size(); i++) begin
      total_cnt++;
      if (rd_addr_log[r0+i] !== exp_rd[i])
        $display("FAIL wrap_read%0d got addr %0d want %0d", i, rd_addr_log[r0+i], exp_rd[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (wr_addr_log.size() - w0 !== 2) $display("FAIL wrap_wr_count got %0d want 2", wr_addr_log.size() - w0);
    else pass_cnt++;
    for (int i = 0; i < 2 && w0 + i < wr_addr_log.size(); i++) begin
      total_cnt++;
      if (wr_addr_log[w0+i] !== 8'(40 + i) || wr_data_log[w0+i] !== exp_wr[i])
        $display("FAIL wrap_write%0d got mem[%0d]=%0d want mem[%0d]=%0d", i, wr_addr_log[w0+i],
                 wr_data_log[w0+i], 40 + i, exp_wr[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_bus_rules();
    total_cnt++;
    if (overlap_cnt !== 0) $display("FAIL bus_overlap got %0d cycles want 0", overlap_cnt);
    else pass_cnt++;
    total_cnt++;
    if (idle_addr_cnt !== 0) $display("FAIL bus_idle_addr got %0d cycles want 0", idle_addr_cnt);
    else pass_cnt++;
    total_cnt++;
    if (lone_err_cnt !== 0) $display("FAIL err_without_done got %0d cycles want 0", lone_err_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_short_job();
    test_reset_mid_job();
    test_start_while_busy();
    test_addr_wrap();
    test_bus_rules();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
